mrelbp_hist_acc: RTL and testbench

Histogram accumulator for the MRELBP pipeline. It sits directly downstream of the LBP-code-to-bin mapping LUT and counts occurrences of each mapped bin index over one image/window. When the window ends it streams the finished histogram out bin by bin under a valid/ready handshake, then clears itself for the next window.

---
 rtl/mrelbp_pkg.sv | 36 +++
 rtl/mrelbp_hist_acc_hist_ram.sv | 39 +++
 rtl/mrelbp_hist_acc.sv | 226 ++++++++++++++++++++++
 tb/tb_mrelbp_hist_acc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mrelbp_pkg.sv
// -----------------------------------------------------------------------------
// mrelbp_pkg
// Shared definitions for the MRELBP histogram accumulator:
//   - state_e      : accumulator FSM states
//   - DEF_BIN_WIDTH / DEF_CNT_WIDTH : default bin index and counter widths
//   - sat_inc()    : saturating +1 on a zero-extended counter value
// -----------------------------------------------------------------------------
package mrelbp_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_READOUT = 2'd3
  } state_e;

  localparam int DEF_BIN_WIDTH = 6;
  localparam int DEF_CNT_WIDTH = 16;

  // Working width of sat_inc(); callers zero-extend counters narrower than this.
  localparam int SAT_W = 32;

  // count+1 is formed one bit wider than the operand so the carry is never
  // lost; anything above max_cnt is clamped to max_cnt.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                              input logic [SAT_W-1:0] max_cnt);
    logic [SAT_W:0] sum;
    sum = {1'b0, cnt} + {{SAT_W{1'b0}}, 1'b1};
    if (sum > {1'b0, max_cnt}) begin
      sat_inc = max_cnt;
    end else begin
      sat_inc = sum[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mrelbp_hist_acc_hist_ram.sv
// -----------------------------------------------------------------------------
// hist_ram
// Simple dual-port counter memory: one synchronous write port and one read
// port whose address is registered (data is read from the registered address).
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address, captured on the clock edge
//   o_rdata  contents of the location addressed by the captured read address
// -----------------------------------------------------------------------------
module hist_ram #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_r [0:(2**AW)-1];
  logic [AW-1:0] raddr_r;

  // Memory write port and read-address register; contents are initialised by
  // the owner's clear sweep, so no reset is applied here.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_waddr] <= i_wdata;
    end
    raddr_r <= i_raddr;
  end

  assign o_rdata = mem_r[raddr_r];

endmodule

// File: rtl/mrelbp_hist_acc.sv
// -----------------------------------------------------------------------------
// mrelbp_hist_acc
// Counts mapped LBP bin indices over one window, then streams the histogram
// out bin by bin and clears itself for the next window.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/i_bin/i_last  sample stream (accepted when i_valid && o_ready)
//   o_ready               high only while accumulating
//   o_hist_valid/_bin/_cnt/_last, i_hist_ready  histogram word handshake
//   o_busy                high whenever not accumulating
// -----------------------------------------------------------------------------
module mrelbp_hist_acc
  import mrelbp_pkg::*;
#(
  parameter int BIN_WIDTH = DEF_BIN_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [BIN_WIDTH-1:0] i_bin,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic                 o_hist_valid,
  output logic [BIN_WIDTH-1:0] o_hist_bin,
  output logic [CNT_WIDTH-1:0] o_hist_cnt,
  output logic                 o_hist_last,
  input  logic                 i_hist_ready,
  output logic                 o_busy
);

  localparam logic [BIN_WIDTH-1:0] BIN_ZERO = {BIN_WIDTH{1'b0}};
  localparam logic [BIN_WIDTH-1:0] BIN_ONE  = {{(BIN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BIN_WIDTH-1:0] BIN_LAST = {BIN_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [SAT_W-CNT_WIDTH-1:0] CNT_PAD = {(SAT_W-CNT_WIDTH){1'b0}};

  state_e               state_r;
  logic [BIN_WIDTH-1:0] clr_ptr_r;
  logic [BIN_WIDTH-1:0] rd_ptr_r;     // mirrors the RAM's registered read address
  logic                 drain_r;

  // RMW stage 1
  logic                 s1_vld_r;
  logic [BIN_WIDTH-1:0] s1_bin_r;
  // Copy of the most recent RMW write, for forwarding
  logic                 wr_vld_r;
  logic [BIN_WIDTH-1:0] wr_bin_r;
  logic [CNT_WIDTH-1:0] wr_cnt_r;

  logic                 o_ready_r;
  logic                 o_busy_r;
  logic                 o_hist_valid_r;
  logic [BIN_WIDTH-1:0] o_hist_bin_r;
  logic [CNT_WIDTH-1:0] o_hist_cnt_r;
  logic                 o_hist_last_r;

  logic                 accept_s;
  logic                 hs_s;
  logic [BIN_WIDTH-1:0] next_bin_s;
  logic [CNT_WIDTH-1:0] ram_rdata_s;
  logic [CNT_WIDTH-1:0] base_cnt_s;
  logic [SAT_W-1:0]     inc_ext_s;
  logic [CNT_WIDTH-1:0] cnt_next_s;
  logic                 ram_we_s;
  logic [BIN_WIDTH-1:0] ram_waddr_s;
  logic [CNT_WIDTH-1:0] ram_wdata_s;
  logic [BIN_WIDTH-1:0] ram_raddr_s;

  assign accept_s   = i_valid && o_ready_r;
  assign hs_s       = o_hist_valid_r && i_hist_ready;
  assign next_bin_s = o_hist_bin_r + BIN_ONE;

  hist_ram #(
    .AW (BIN_WIDTH),
    .DW (CNT_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we_s),
    .i_waddr (ram_waddr_s),
    .i_wdata (ram_wdata_s),
    .i_raddr (ram_raddr_s),
    .o_rdata (ram_rdata_s)
  );

  // Stage-2 increment: take the last written count when it targets the same
  // bin, so a read port returning pre-write data can never lose an increment.
  always_comb begin
    base_cnt_s = ram_rdata_s;
    if (wr_vld_r && (wr_bin_r == s1_bin_r)) begin
      base_cnt_s = wr_cnt_r;
    end else begin
      base_cnt_s = ram_rdata_s;
    end
    inc_ext_s  = sat_inc({CNT_PAD, base_cnt_s}, {CNT_PAD, CNT_MAX});
    cnt_next_s = inc_ext_s[CNT_WIDTH-1:0];
  end

  // RAM port muxing: clear sweep, RMW write-back, and readout prefetch share
  // the single memory. The read address always points one word ahead of the
  // registered output during readout.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = BIN_ZERO;
    ram_wdata_s = CNT_ZERO;
    ram_raddr_s = BIN_ZERO;
    case (state_r)
      ST_CLEAR: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = clr_ptr_r;
        ram_wdata_s = CNT_ZERO;
        ram_raddr_s = BIN_ZERO;
      end
      ST_ACCUM, ST_DRAIN: begin
        ram_we_s    = s1_vld_r;
        ram_waddr_s = s1_bin_r;
        ram_wdata_s = cnt_next_s;
        if (state_r == ST_ACCUM) begin
          ram_raddr_s = i_bin;
        end else if (drain_r) begin
          ram_raddr_s = BIN_ONE;
        end else begin
          ram_raddr_s = BIN_ZERO;
        end
      end
      ST_READOUT: begin
        if (hs_s) begin
          ram_raddr_s = rd_ptr_r + BIN_ONE;
        end else begin
          ram_raddr_s = rd_ptr_r;
        end
      end
      default: begin
        ram_we_s    = 1'b0;
        ram_raddr_s = BIN_ZERO;
      end
    endcase
  end

  // Control FSM, RMW pipeline registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r        <= ST_CLEAR;
      clr_ptr_r      <= BIN_ZERO;
      rd_ptr_r       <= BIN_ZERO;
      drain_r        <= 1'b0;
      s1_vld_r       <= 1'b0;
      s1_bin_r       <= BIN_ZERO;
      wr_vld_r       <= 1'b0;
      wr_bin_r       <= BIN_ZERO;
      wr_cnt_r       <= CNT_ZERO;
      o_ready_r      <= 1'b0;
      o_busy_r       <= 1'b1;
      o_hist_valid_r <= 1'b0;
      o_hist_bin_r   <= BIN_ZERO;
      o_hist_cnt_r   <= CNT_ZERO;
      o_hist_last_r  <= 1'b0;
    end else begin
      s1_vld_r <= accept_s;
      s1_bin_r <= i_bin;
      wr_vld_r <= s1_vld_r;
      wr_bin_r <= s1_bin_r;
      wr_cnt_r <= cnt_next_s;
      rd_ptr_r <= ram_raddr_s;
      case (state_r)
        ST_CLEAR: begin
          clr_ptr_r <= clr_ptr_r + BIN_ONE;
          if (clr_ptr_r == BIN_LAST) begin
            state_r   <= ST_ACCUM;
            o_ready_r <= 1'b1;
            o_busy_r  <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (accept_s && i_last) begin
            state_r   <= ST_DRAIN;
            drain_r   <= 1'b0;
            o_ready_r <= 1'b0;
            o_busy_r  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          drain_r <= 1'b1;
          if (drain_r) begin
            // Pipeline is empty; bin 0 is already on the read port.
            state_r        <= ST_READOUT;
            o_hist_valid_r <= 1'b1;
            o_hist_bin_r   <= BIN_ZERO;
            o_hist_cnt_r   <= ram_rdata_s;
            o_hist_last_r  <= (BIN_ZERO == BIN_LAST);
          end
        end
        ST_READOUT: begin
          if (hs_s) begin
            if (o_hist_last_r) begin
              state_r        <= ST_CLEAR;
              clr_ptr_r      <= BIN_ZERO;
              o_hist_valid_r <= 1'b0;
              o_hist_last_r  <= 1'b0;
            end else begin
              o_hist_bin_r  <= next_bin_s;
              o_hist_cnt_r  <= ram_rdata_s;
              o_hist_last_r <= (next_bin_s == BIN_LAST);
            end
          end
        end
        default: begin
          state_r        <= ST_CLEAR;
          clr_ptr_r      <= BIN_ZERO;
          o_ready_r      <= 1'b0;
          o_busy_r       <= 1'b1;
          o_hist_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready      = o_ready_r;
  assign o_busy       = o_busy_r;
  assign o_hist_valid = o_hist_valid_r;
  assign o_hist_bin   = o_hist_bin_r;
  assign o_hist_cnt   = o_hist_cnt_r;
  assign o_hist_last  = o_hist_last_r;

endmodule

// File: tb/tb_mrelbp_hist_acc.sv
// Bench for mrelbp_hist_acc: a 16-bit-counter and a 4-bit-counter instance
// share one stimulus stream; expected histogram words are queued at the end of
// each window and popped on every readout handshake.
module tb_mrelbp_hist_acc;

  logic       clk = 1'b0;
  logic       i_rst, i_valid, i_last, i_hist_ready;
  logic [5:0] i_bin;

  logic        o_ready, o_busy, o_hist_valid, o_hist_last;
  logic [5:0]  o_hist_bin;
  logic [15:0] o_hist_cnt;
  logic        r4, b4, v4, l4;
  logic [5:0]  hb4;
  logic [3:0]  hc4;

  always #5 clk = ~clk;

  mrelbp_hist_acc #(.BIN_WIDTH(6), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_bin(i_bin), .i_last(i_last),
    .o_ready(o_ready), .o_hist_valid(o_hist_valid), .o_hist_bin(o_hist_bin),
    .o_hist_cnt(o_hist_cnt), .o_hist_last(o_hist_last), .i_hist_ready(i_hist_ready),
    .o_busy(o_busy));

  mrelbp_hist_acc #(.BIN_WIDTH(6), .CNT_WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_bin(i_bin), .i_last(i_last),
    .o_ready(r4), .o_hist_valid(v4), .o_hist_bin(hb4),
    .o_hist_cnt(hc4), .o_hist_last(l4), .i_hist_ready(i_hist_ready),
    .o_busy(b4));

  typedef struct packed {
    logic [5:0]  bin;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   stim_q[$];
  int   hist[64];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    foreach (hist[b]) hist[b] = 0;
  endtask

  // Counts negedges until o_ready rises; optionally throws junk samples at the
  // block during the clear sweep, which must not be counted.
  task automatic wait_ready(input string tag, input bit junk);
    int n = 0;
    while (!o_ready && n < 200) begin
      if (junk && n < 60) begin
        i_valid = 1'b1;
        i_bin   = 6'($urandom_range(0, 63));
        i_last  = 1'($urandom_range(0, 1));
      end else begin
        i_valid = 1'b0;
        i_last  = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk(tag, n, 64);
    chk("busy_in_accum", int'(o_busy), 0);
    chk("ready4", int'(r4), 1);
  endtask

  task automatic do_reset(input bit junk);
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_last = 1'b0;
    i_hist_ready = 1'b0;
    @(negedge clk);
    chk("rst_hist_valid", int'(o_hist_valid), 0);
    chk("rst_ready", int'(o_ready), 0);
    @(negedge clk);
    chk("rst_busy", int'(o_busy), 1);
    chk("rst_bin", int'(o_hist_bin), 0);
    chk("rst_cnt", int'(o_hist_cnt), 0);
    chk("rst_last", int'(o_hist_last), 0);
    sb_q.delete();
    clear_model();
    i_rst = 1'b0;
    wait_ready("clear_len_rst", junk);
  endtask

  // Sends stim_q as one window (last on final sample when with_last) and, at
  // window end, checks the drain timing and queues the expected histogram.
  task automatic send_window(input bit gaps, input bit with_last);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          i_valid = 1'b0;
          @(negedge clk);
        end
      end
      i_valid = 1'b1;
      i_bin   = 6'(stim_q[i]);
      i_last  = with_last && (i == stim_q.size() - 1);
      hist[stim_q[i]]++;
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (with_last) begin
      chk("ready_drop", int'(o_ready), 0);
      chk("busy_drain", int'(o_busy), 1);
      @(negedge clk);
      chk("drain_no_valid", int'(o_hist_valid), 0);
      @(negedge clk);
      chk("first_valid", int'(o_hist_valid), 1);
      chk("first_bin", int'(o_hist_bin), 0);
      for (int b = 0; b < 64; b++) begin
        exp_t e;
        e.bin  = 6'(b);
        e.cnt  = 16'((hist[b] > 65535) ? 65535 : hist[b]);
        e.cnt4 = 4'((hist[b] > 15) ? 15 : hist[b]);
        e.last = (b == 63);
        sb_q.push_back(e);
      end
      clear_model();
    end
  endtask

  // mode 0: ready held high, 1: pattern 1,0,0,1, 2: random ready.
  task automatic readout(input int mode, input int nhs);
    int   n = 0;
    int   cyc = 0;
    bit   stalled = 1'b0;
    bit   rdy;
    exp_t held, e;
    bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (n < nhs && cyc < 1000) begin
      if (stalled) begin
        chk("stall_valid", int'(o_hist_valid), 1);
        chk("stall_bin", int'(o_hist_bin), int'(held.bin));
        chk("stall_cnt", int'(o_hist_cnt), int'(held.cnt));
        chk("stall_last", int'(o_hist_last), int'(held.last));
      end
      case (mode)
        1:       rdy = pat[cyc % 4];
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      i_hist_ready = rdy;
      stalled = 1'b0;
      if (o_hist_valid && rdy) begin
        chk("sb_nonempty", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rd_bin", int'(o_hist_bin), int'(e.bin));
          chk("rd_cnt", int'(o_hist_cnt), int'(e.cnt));
          chk("rd_last", int'(o_hist_last), int'(e.last));
          chk("rd_valid4", int'(v4), 1);
          chk("rd_cnt4", int'(hc4), int'(e.cnt4));
        end
        n++;
      end else if (o_hist_valid) begin
        held.bin  = o_hist_bin;
        held.cnt  = o_hist_cnt;
        held.last = o_hist_last;
        held.cnt4 = hc4;
        stalled   = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    i_hist_ready = 1'b0;
    chk("hs_count", n, nhs);
    if (nhs == 64) begin
      chk("valid_drop", int'(o_hist_valid), 0);
      chk("sb_drained", sb_q.size(), 0);
      wait_ready("clear_len_rd", 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_last = 1'b0;
    i_bin = 6'd0;
    i_hist_ready = 1'b0;
    clear_model();
    do_reset(1'b1);

    // Only bin 0, with last.
    stim_q = {0};
    send_window(1'b0, 1'b1);
    readout(0, 64);

    // Mixed bins, stalled readout.
    stim_q = {3, 3, 7, 3, 63};
    send_window(1'b0, 1'b1);
    readout(1, 64);

    // Back-to-back hits on one bin.
    stim_q = {9, 9, 9, 9, 9, 9};
    send_window(1'b0, 1'b1);
    readout(0, 64);

    // Saturation on the 4-bit instance.
    stim_q = {};
    for (int i = 0; i < 20; i++) stim_q.push_back(2);
    send_window(1'b0, 1'b1);
    readout(2, 64);

    // Random window with gaps and random readout backpressure.
    stim_q = {};
    for (int i = 0; i < 150; i++) stim_q.push_back($urandom_range(0, 63));
    send_window(1'b1, 1'b1);
    readout(2, 64);

    // Reset in the middle of accumulation.
    stim_q = {4, 4, 4, 10};
    send_window(1'b0, 1'b0);
    do_reset(1'b0);
    stim_q = {5, 5};
    send_window(1'b0, 1'b1);
    readout(0, 64);

    // Reset in the middle of readout.
    stim_q = {1, 2, 3};
    send_window(1'b0, 1'b1);
    readout(1, 10);
    do_reset(1'b0);
    stim_q = {12};
    send_window(1'b0, 1'b1);
    readout(0, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
